instr_fetch_mem: RTL

- Parametrised, clocked instruction memory for the RISC-V pipeline fetch stage; the next generation of the combinational instruction ROM.
- Adds a registered 1-cycle read, stall handshake, and alignment/range fault flags.
- Adds a runtime program-load port.
- Replaces the ad-hoc simulation stop with an explicit end-of-program drain FSM that raises `halt` once the pipeline has emptied.

---
 rtl/instr_fetch_mem.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory for the fetch stage: registered 1-cycle read, stall
// hold, alignment/range faults, runtime program load and an end-of-program drain FSM.
module instr_fetch_mem #(
  parameter int              DEPTH        = 256,
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BASE_ADDR    = '0,
  parameter int              DRAIN_CYCLES = 5,
  parameter logic [31:0]     NOP_WORD     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          pc,
  input  logic                     fetch_en,
  input  logic                     stall,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic [31:0]              instr,
  output logic [XLEN-1:0]          instr_pc,
  output logic                     instr_valid,
  output logic                     misaligned,
  output logic                     out_of_range,
  output logic                     halt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  logic [31:0]     mem [DEPTH];
  state_t          state, state_d;
  logic [CW-1:0]   drain_cnt, drain_cnt_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] instr_pc_d;
  logic            instr_valid_d, misaligned_d, out_of_range_d, halt_d;

  logic [XLEN-1:0] offset, word_idx;
  logic            is_misaligned, is_oor;
  logic [31:0]     rd_word;

  // The index is formed at full width so addresses that would alias past DEPTH
  // are flagged out of range instead of wrapping.
  assign offset        = pc - BASE_ADDR;
  assign word_idx      = offset >> 2;
  assign is_misaligned = (pc[1:0] != 2'b00);
  assign is_oor        = (pc < BASE_ADDR) || (word_idx >= XLEN'(DEPTH));
  assign rd_word       = mem[word_idx[AW-1:0]];

  // Loads are honoured in every state, reset and stall included; reads above see
  // the pre-write contents, giving read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      drain_cnt    <= '0;
      instr        <= NOP_WORD;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
      halt         <= 1'b0;
    end else begin
      state        <= state_d;
      drain_cnt    <= drain_cnt_d;
      instr        <= instr_d;
      instr_pc     <= instr_pc_d;
      instr_valid  <= instr_valid_d;
      misaligned   <= misaligned_d;
      out_of_range <= out_of_range_d;
      halt         <= halt_d;
    end
  end

  always_comb begin
    state_d        = state;
    drain_cnt_d    = drain_cnt;
    instr_d        = instr;
    instr_pc_d     = instr_pc;
    instr_valid_d  = instr_valid;
    misaligned_d   = misaligned;
    out_of_range_d = out_of_range;
    halt_d         = halt;

    if (!stall) begin
      unique case (state)
        RUN: begin
          instr_valid_d = fetch_en;
          if (fetch_en) begin
            instr_pc_d     = pc;
            misaligned_d   = is_misaligned;
            out_of_range_d = !is_misaligned && is_oor;
            // Faults take priority over the terminator so they never start a drain.
            if (is_misaligned || is_oor) begin
              instr_d = NOP_WORD;
            end else if (rd_word == 32'h0) begin
              instr_d     = NOP_WORD;
              state_d     = DRAIN;
              drain_cnt_d = CW'(DRAIN_CYCLES);
            end else begin
              instr_d = rd_word;
            end
          end
        end

        DRAIN: begin
          drain_cnt_d   = drain_cnt - CW'(1);
          instr_valid_d = fetch_en;
          if (fetch_en) begin
            instr_pc_d     = pc;
            misaligned_d   = is_misaligned;
            out_of_range_d = !is_misaligned && is_oor;
            instr_d        = NOP_WORD;
          end
          if (drain_cnt == CW'(1)) begin
            state_d       = HALTED;
            halt_d        = 1'b1;
            instr_valid_d = 1'b0;
          end
        end

        HALTED: begin
          instr_valid_d = 1'b0;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

endmodule
